// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory-stage controller: Ctrl bit positions,
// FSM state encoding and decoded operation class.
package mem_ctrl_pkg;

    localparam int CTRL_W     = 7;
    localparam int BIT_RD     = 6;
    localparam int BIT_WORD   = 5;
    localparam int BIT_RSVD   = 4;
    localparam int BIT_INC    = 3;
    localparam int BIT_ROMSEL = 2;
    localparam int BIT_WB     = 1;
    localparam int BIT_WR     = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KWAIT,
        S_RWAIT,
        S_WRITE,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_KREAD,
        OP_PREAD,
        OP_WRITE,
        OP_ILLEGAL
    } op_t;

    // Illegal combinations take priority over any access decode.
    function automatic op_t classify(input logic [CTRL_W-1:0] ctrl);
        op_t op;
        op = OP_NONE;
        if ((ctrl[BIT_RD] && ctrl[BIT_WR]) || (ctrl[BIT_WR] && ctrl[BIT_ROMSEL]))
            op = OP_ILLEGAL;
        else if (ctrl[BIT_RD])
            op = ctrl[BIT_ROMSEL] ? OP_PREAD : OP_KREAD;
        else if (ctrl[BIT_WR])
            op = OP_WRITE;
        return op;
    endfunction

endpackage

// File: rtl/wrap_ptr.sv
// Up-counter with an increment strobe that wraps from N-1 back to zero.
module wrap_ptr #(
    parameter int W = 4,
    parameter int N = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr <= '0;
        else if (inc)
            ptr <= (ptr == W'(N - 1)) ? '0 : ptr + 1'b1;
    end

endmodule

// File: rtl/mem_section_ctrl.sv
// Memory-stage responder: kernel reads, image-ROM pixel reads and output-RAM
// writes, with auto-incrementing pointers and a combinational pipeline stall.
module mem_section_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int KADDR_W  = 4,
    parameter int KER_SIZE = 9,
    parameter int IADDR_W  = 16,
    parameter int IMG_PIX  = 65536,
    parameter int OADDR_W  = 16,
    parameter int ROM_LAT  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               m_valid,
    input  logic [CTRL_W-1:0]  m_ctrl,
    input  logic [31:0]        m_addr,
    input  logic [DATA_W-1:0]  m_wdata,
    output logic               m_stall,
    output logic [DATA_W-1:0]  m_rdata,
    output logic               m_rvalid,
    output logic               m_err,
    output logic               kmem_en,
    output logic [KADDR_W-1:0] kmem_addr,
    input  logic [DATA_W-1:0]  kmem_rdata,
    output logic               irom_en,
    output logic [IADDR_W-1:0] irom_addr,
    input  logic [7:0]         irom_rdata,
    output logic               oram_we,
    output logic [OADDR_W-1:0] oram_addr,
    output logic [DATA_W-1:0]  oram_wdata,
    input  logic               oram_ready
);

    localparam int CNT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    state_t              state, state_nxt;
    op_t                 op;
    logic                idle_valid;
    logic [CNT_W-1:0]    lat_cnt;
    logic [DATA_W-1:0]   rdata_q;
    logic                wb_q;
    logic [OADDR_W-1:0]  waddr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   store_data;
    logic [KADDR_W-1:0]  kptr;
    logic [IADDR_W-1:0]  pptr;
    logic                unused_ok;

    assign op = classify(m_ctrl);

    // NOTE: reset also gates the accept decode so no enable, stall or error
    // can leak out combinationally while reset is held with m_valid high.
    assign idle_valid = (state == S_IDLE) && m_valid && !reset;

    assign store_data = m_ctrl[BIT_WORD] ? m_wdata : {{(DATA_W-8){1'b0}}, m_wdata[7:0]};
    assign kmem_addr  = m_ctrl[BIT_INC] ? kptr : m_addr[KADDR_W-1:0];
    assign irom_addr  = m_ctrl[BIT_INC] ? pptr : m_addr[IADDR_W-1:0];
    assign oram_addr  = (state == S_WRITE) ? waddr_q : m_addr[OADDR_W-1:0];
    assign oram_wdata = (state == S_WRITE) ? wdata_q : store_data;
    assign m_rdata    = rdata_q;
    assign unused_ok  = ^{m_ctrl[BIT_RSVD], m_addr};

    wrap_ptr #(.W(KADDR_W), .N(KER_SIZE)) u_kptr (
        .clk   (clk),
        .reset (reset),
        .inc   (kmem_en && m_ctrl[BIT_INC]),
        .ptr   (kptr)
    );

    wrap_ptr #(.W(IADDR_W), .N(IMG_PIX)) u_pptr (
        .clk   (clk),
        .reset (reset),
        .inc   (irom_en && m_ctrl[BIT_INC]),
        .ptr   (pptr)
    );

    // NOTE: every output of this block gets a default first, so no path through
    // the case statement can infer a latch.
    always_comb begin
        state_nxt = state;
        m_stall   = 1'b0;
        m_err     = 1'b0;
        m_rvalid  = 1'b0;
        kmem_en   = 1'b0;
        irom_en   = 1'b0;
        oram_we   = 1'b0;
        case (state)
            S_IDLE: begin
                if (idle_valid) begin
                    case (op)
                        OP_KREAD: begin
                            kmem_en   = 1'b1;
                            m_stall   = 1'b1;
                            state_nxt = S_KWAIT;
                        end
                        OP_PREAD: begin
                            irom_en   = 1'b1;
                            m_stall   = 1'b1;
                            state_nxt = S_RWAIT;
                        end
                        OP_WRITE: begin
                            oram_we   = 1'b1;
                            m_stall   = !oram_ready;
                            state_nxt = oram_ready ? S_DONE : S_WRITE;
                        end
                        OP_ILLEGAL: m_err = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_KWAIT: begin
                m_stall   = 1'b1;
                state_nxt = S_DONE;
            end
            S_RWAIT: begin
                m_stall = 1'b1;
                if (lat_cnt == '0)
                    state_nxt = S_DONE;
            end
            S_WRITE: begin
                m_stall = 1'b1;
                oram_we = 1'b1;
                if (oram_ready)
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                m_rvalid  = wb_q;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            lat_cnt <= '0;
            rdata_q <= '0;
            wb_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE)
                wb_q <= m_ctrl[BIT_WB] && m_ctrl[BIT_RD];
            if (irom_en)
                lat_cnt <= CNT_W'(ROM_LAT - 1);
            else if (state == S_RWAIT && lat_cnt != '0)
                lat_cnt <= lat_cnt - 1'b1;
            if (state == S_KWAIT)
                rdata_q <= kmem_rdata;
            if (state == S_RWAIT && lat_cnt == '0)
                rdata_q <= {{(DATA_W-8){1'b0}}, irom_rdata};
            // Address and data are captured so the write stays stable while RAM is busy.
            if (oram_we && state == S_IDLE) begin
                waddr_q <= m_addr[OADDR_W-1:0];
                wdata_q <= store_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_section_ctrl.sv
// Scoreboard bench for mem_section_ctrl: a driver issues instructions and
// queues expected responses; a negedge monitor pops and compares them.
module tb_mem_section_ctrl;

    localparam int DATA_W   = 32;
    localparam int KADDR_W  = 4;
    localparam int KER_SIZE = 9;
    localparam int IADDR_W  = 16;
    localparam int IMG_PIX  = 65536;
    localparam int OADDR_W  = 16;
    localparam int ROM_LAT  = 2;

    localparam int EV_K = 0;
    localparam int EV_P = 1;
    localparam int EV_W = 2;
    localparam int EV_R = 3;
    localparam int EV_E = 4;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    logic               clk;
    logic               reset;
    logic               m_valid;
    logic [6:0]         m_ctrl;
    logic [31:0]        m_addr;
    logic [DATA_W-1:0]  m_wdata;
    logic               m_stall;
    logic [DATA_W-1:0]  m_rdata;
    logic               m_rvalid;
    logic               m_err;
    logic               kmem_en;
    logic [KADDR_W-1:0] kmem_addr;
    logic [DATA_W-1:0]  kmem_rdata;
    logic               irom_en;
    logic [IADDR_W-1:0] irom_addr;
    logic [7:0]         irom_rdata;
    logic               oram_we;
    logic [OADDR_W-1:0] oram_addr;
    logic [DATA_W-1:0]  oram_wdata;
    logic               oram_ready;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          kptr_m = 0;
    int          pptr_m = 0;
    ev_t         exp_q[$];
    logic [31:0] kmem [16];
    logic [7:0]  rom_pipe [ROM_LAT];

    mem_section_ctrl #(
        .DATA_W(DATA_W), .KADDR_W(KADDR_W), .KER_SIZE(KER_SIZE), .IADDR_W(IADDR_W),
        .IMG_PIX(IMG_PIX), .OADDR_W(OADDR_W), .ROM_LAT(ROM_LAT)
    ) dut (
        .clk(clk), .reset(reset), .m_valid(m_valid), .m_ctrl(m_ctrl), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_stall(m_stall), .m_rdata(m_rdata), .m_rvalid(m_rvalid),
        .m_err(m_err), .kmem_en(kmem_en), .kmem_addr(kmem_addr), .kmem_rdata(kmem_rdata),
        .irom_en(irom_en), .irom_addr(irom_addr), .irom_rdata(irom_rdata),
        .oram_we(oram_we), .oram_addr(oram_addr), .oram_wdata(oram_wdata),
        .oram_ready(oram_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] pix(input int a);
        return 8'((a * 13) ^ (a >> 5) ^ 32'hA5);
    endfunction

    function automatic string ev_name(input int kind);
        case (kind)
            EV_K:    return "kmem_read";
            EV_P:    return "irom_read";
            EV_W:    return "oram_write";
            EV_R:    return "rdata";
            default: return "err";
        endcase
    endfunction

    // Environment memories: 1-cycle kernel RAM and a ROM_LAT-deep pixel ROM.
    always @(posedge clk) begin
        kmem_rdata  <= kmem_en ? kmem[kmem_addr] : (32'hDEAD_0000 ^ 32'(cyc));
        rom_pipe[0] <= irom_en ? pix(int'(irom_addr)) : 8'h00;
        for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign irom_rdata = rom_pipe[ROM_LAT-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int c, input logic [31:0] addr, input logic [31:0] data);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic take(input int kind, input logic [31:0] addr, input logic [31:0] data);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_%s: got addr 0x%08h data 0x%08h, expected no response (cycle %0d)",
                     ev_name(kind), addr, data, cyc);
            return;
        end
        e = exp_q.pop_front();
        check("event_kind", 32'(kind), 32'(e.kind));
        check({ev_name(kind), "_cycle"}, 32'(cyc), 32'(e.cyc));
        check({ev_name(kind), "_addr"}, addr, e.addr);
        check({ev_name(kind), "_data"}, data, e.data);
    endtask

    always @(negedge clk) begin
        if (kmem_en) take(EV_K, 32'(kmem_addr), 32'h0);
        if (irom_en) take(EV_P, 32'(irom_addr), 32'h0);
        if (oram_we) begin
            if (oram_ready)
                take(EV_W, 32'(oram_addr), oram_wdata);
            else if (exp_q.size() > 0 && exp_q[0].kind == EV_W) begin
                check("oram_addr_hold", 32'(oram_addr), exp_q[0].addr);
                check("oram_wdata_hold", oram_wdata, exp_q[0].data);
            end else
                take(EV_W, 32'(oram_addr), oram_wdata);
        end
        if (m_rvalid) take(EV_R, 32'h0, m_rdata);
        if (m_err) take(EV_E, 32'h0, 32'h0);
    end

    // Issue one instruction (inputs change at posedge+1), hold it while stalled,
    // and record what the pipeline should observe. d = cycles oram_ready stays low.
    task automatic issue(input logic [6:0] ctrl, input logic [31:0] addr,
                         input logic [31:0] wdata, input int d);
        bit rd, wr, rom, inc, wb, word, is_write, done;
        int exp_stall, stalled, k, a;
        rd = ctrl[6]; word = ctrl[5]; inc = ctrl[3]; rom = ctrl[2]; wb = ctrl[1]; wr = ctrl[0];
        exp_stall = 0; stalled = 0; k = 0; done = 0; is_write = 0;
        if (!rd && !wr) begin
        end else if ((rd && wr) || (wr && rom)) begin
            push(EV_E, cyc, 32'h0, 32'h0);
        end else if (rd && !rom) begin
            a = inc ? kptr_m : int'(addr[KADDR_W-1:0]);
            if (inc) kptr_m = (kptr_m + 1) % KER_SIZE;
            push(EV_K, cyc, 32'(a), 32'h0);
            if (wb) push(EV_R, cyc + 2, 32'h0, kmem[a]);
            exp_stall = 2;
        end else if (rd) begin
            a = inc ? pptr_m : int'(addr[IADDR_W-1:0]);
            if (inc) pptr_m = (pptr_m + 1) % IMG_PIX;
            push(EV_P, cyc, 32'(a), 32'h0);
            if (wb) push(EV_R, cyc + ROM_LAT + 1, 32'h0, {24'h0, pix(a)});
            exp_stall = ROM_LAT + 1;
        end else begin
            is_write = 1;
            push(EV_W, cyc + d, {16'h0, addr[15:0]}, word ? wdata : {24'h0, wdata[7:0]});
            exp_stall = (d == 0) ? 0 : d + 1;
        end
        m_valid = 1'b1; m_ctrl = ctrl; m_addr = addr; m_wdata = wdata;
        oram_ready = is_write && (d == 0);
        while (!done) begin
            @(negedge clk);
            if (m_stall) stalled++;
            else done = 1;
            @(posedge clk); #1;
            k++;
            oram_ready = is_write && (k >= d);
            if (k > 60 && !done) begin
                checks++; errors++;
                $display("FAIL stall_timeout: stall still high after %0d cycles, expected release", k);
                done = 1;
            end
        end
        m_valid = 1'b0; oram_ready = 1'b0;
        check($sformatf("stall_cycles_ctrl_%02h", ctrl), 32'(stalled), 32'(exp_stall));
        if (is_write && d == 0) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [6:0] c;
        for (int i = 0; i < 16; i++) kmem[i] = $urandom;
        reset = 1'b1; m_valid = 1'b0; m_ctrl = '0; m_addr = '0; m_wdata = '0; oram_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_m_stall", 32'(m_stall), 32'h0);
        check("reset_m_rvalid", 32'(m_rvalid), 32'h0);
        check("reset_m_err", 32'(m_err), 32'h0);
        check("reset_kmem_en", 32'(kmem_en), 32'h0);
        check("reset_irom_en", 32'(irom_en), 32'h0);
        check("reset_oram_we", 32'(oram_we), 32'h0);
        check("reset_m_rdata", m_rdata, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Kernel pointer walks 0..8 then wraps to 0.
        for (int i = 0; i < 10; i++) issue(7'h6A, $urandom, 32'h0, 0);
        // Pixel reads through the pointer: rom[0] = 0xA5.
        issue(7'h4E, 32'h0, 32'h0, 0);
        issue(7'h4E, 32'h0, 32'h0, 0);
        // Word write with a busy RAM, then a byte write accepted immediately.
        issue(7'h21, 32'h40, 32'h1122_3344, 3);
        issue(7'h01, 32'h1_0123, 32'hDEAD_BEEF, 0);
        // Illegal combinations, then a kernel read showing the pointer unchanged.
        issue(7'h41, 32'h5, 32'h0, 0);
        issue(7'h05, 32'h5, 32'h0, 0);
        issue(7'h6A, 32'h0, 32'h0, 0);
        // Explicit-address reads back to back, and one without writeback.
        issue(7'h62, 32'h0000_000D, 32'h0, 0);
        issue(7'h46, 32'h0000_BEEF, 32'h0, 0);
        issue(7'h40, 32'h3, 32'h0, 0);

        for (int n = 0; n < 150; n++) begin
            c = 7'($urandom);
            if (c[0] && !c[6] && !c[2]) c[3] = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            issue(c, $urandom, $urandom, $urandom_range(0, 4));
        end

        // Reset while a pixel read is waiting on the ROM.
        push(EV_P, cyc, 32'(pptr_m), 32'h0);
        m_valid = 1'b1; m_ctrl = 7'h4E; m_addr = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete();
        kptr_m = 0; pptr_m = 0;
        @(negedge clk);
        check("rst_rwait_m_stall", 32'(m_stall), 32'h0);
        check("rst_rwait_irom_en", 32'(irom_en), 32'h0);
        check("rst_rwait_m_rdata", m_rdata, 32'h0);
        @(posedge clk); #1;
        m_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (ROM_LAT + 3) @(posedge clk);
        #1;
        issue(7'h4E, 32'h0, 32'h0, 0);
        issue(7'h6A, 32'h0, 32'h0, 0);
        for (int n = 0; n < 40; n++) begin
            c = 7'($urandom);
            if (c[0] && !c[6] && !c[2]) c[3] = 1'b0;
            issue(c, $urandom, $urandom, $urandom_range(0, 3));
        end

        repeat (6) @(posedge clk);
        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
